// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared axis timing type, VGA 640x480 constants and window helper
package vga_timing_pkg;

  // One axis worth of timing: counter period plus the three decoded windows
  typedef struct packed {
    int unsigned total;
    int unsigned act_end;
    int unsigned sync_begin;
    int unsigned sync_end;
    int unsigned se_begin;
    int unsigned se_end;
  } vga_axis_t;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam vga_axis_t VGA640_H = '{total: 800, act_end: 640, sync_begin: 656,
                                     sync_end: 752, se_begin: 64, se_end: 576};
  localparam vga_axis_t VGA640_V = '{total: 525, act_end: 480, sync_begin: 490,
                                     sync_end: 492, se_begin: 69, se_end: 411};

  // Half-open window test: lo <= c < hi
  function automatic logic in_window(int unsigned c, int unsigned lo, int unsigned hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_axis_count.sv
// rtl/vga_axis_count.sv - one timing axis: wrapping counter, registered sync, next-count window decode
module vga_axis_count
  import vga_timing_pkg::*;
#(
  parameter int          CW         = 10,
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned ACT_END    = 640,
  parameter int unsigned SYNC_BEGIN = 656,
  parameter int unsigned SYNC_END   = 752,
  parameter int unsigned SE_BEGIN   = 64,
  parameter int unsigned SE_END     = 576,
  parameter sync_pol_e   SYNC_POL   = SYNC_ACTIVE_LOW
) (
  input  logic          clock,
  input  logic          nReset,
  input  logic          step,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          atEnd,
  output logic          sync,
  output logic          active,
  output logic          seActive
);

  if (TOTAL > 2 ** CW) begin : g_bad_total
    $fatal(1, "vga_axis_count: TOTAL does not fit in CW bits");
  end
  if (!(SYNC_BEGIN < SYNC_END && SYNC_END <= TOTAL)) begin : g_bad_sync
    $fatal(1, "vga_axis_count: sync window out of order or beyond TOTAL");
  end
  if (!(SE_BEGIN < SE_END && SE_END <= TOTAL)) begin : g_bad_se
    $fatal(1, "vga_axis_count: SE window out of order or beyond TOTAL");
  end
  if (!(ACT_END > 0 && ACT_END <= TOTAL)) begin : g_bad_act
    $fatal(1, "vga_axis_count: ACT_END must be in 1..TOTAL");
  end

  localparam logic SYNC_ON  = logic'(SYNC_POL);
  localparam logic SYNC_OFF = ~logic'(SYNC_POL);

  logic [CW-1:0] count_next;

  assign atEnd = (count == CW'(TOTAL - 1));

  // Next count: clear beats step; wrap at TOTAL-1 so no out-of-range state exists
  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (step) begin
      count_next = atEnd ? '0 : count + 1'b1;
    end
  end

  // Window decodes of the next count; the parent registers their combination
  assign active   = in_window(32'(count_next), 0, ACT_END);
  assign seActive = in_window(32'(count_next), SE_BEGIN, SE_END);

  // Counter and sync registered together so sync is aligned with count
  always_ff @(negedge clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
      sync  <= in_window(0, SYNC_BEGIN, SYNC_END) ? SYNC_ON : SYNC_OFF;
    end else begin
      count <= count_next;
      sync  <= in_window(32'(count_next), SYNC_BEGIN, SYNC_END) ? SYNC_ON : SYNC_OFF;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - two-axis VGA timing generator with SE window and line/frame strobes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int          CW           = 10,
  parameter int unsigned H_TOTAL      = VGA640_H.total,
  parameter int unsigned H_ACT_END    = VGA640_H.act_end,
  parameter int unsigned H_SYNC_BEGIN = VGA640_H.sync_begin,
  parameter int unsigned H_SYNC_END   = VGA640_H.sync_end,
  parameter int unsigned H_SE_BEGIN   = VGA640_H.se_begin,
  parameter int unsigned H_SE_END     = VGA640_H.se_end,
  parameter int unsigned V_TOTAL      = VGA640_V.total,
  parameter int unsigned V_ACT_END    = VGA640_V.act_end,
  parameter int unsigned V_SYNC_BEGIN = VGA640_V.sync_begin,
  parameter int unsigned V_SYNC_END   = VGA640_V.sync_end,
  parameter int unsigned V_SE_BEGIN   = VGA640_V.se_begin,
  parameter int unsigned V_SE_END     = VGA640_V.se_end,
  parameter sync_pol_e   H_SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter sync_pol_e   V_SYNC_POL   = SYNC_ACTIVE_LOW
) (
  input  logic          clock,
  input  logic          nReset,
  input  logic          ce,
  input  logic          resync,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          hSync,
  output logic          vSync,
  output logic          activeVid,
  output logic          activeSE,
  output logic          lineStart,
  output logic          frameStart
);

  localparam logic VID_AT_ORIGIN = in_window(0, 0, H_ACT_END) & in_window(0, 0, V_ACT_END);
  localparam logic SE_AT_ORIGIN  = in_window(0, H_SE_BEGIN, H_SE_END) &
                                   in_window(0, V_SE_BEGIN, V_SE_END);

  logic h_at_end, v_at_end;
  logic h_act_next, v_act_next, h_se_next, v_se_next;

  vga_axis_count #(
    .CW(CW), .TOTAL(H_TOTAL), .ACT_END(H_ACT_END),
    .SYNC_BEGIN(H_SYNC_BEGIN), .SYNC_END(H_SYNC_END),
    .SE_BEGIN(H_SE_BEGIN), .SE_END(H_SE_END), .SYNC_POL(H_SYNC_POL)
  ) u_h (
    .clock(clock), .nReset(nReset), .step(ce), .clear(resync),
    .count(hCount), .atEnd(h_at_end), .sync(hSync),
    .active(h_act_next), .seActive(h_se_next)
  );

  vga_axis_count #(
    .CW(CW), .TOTAL(V_TOTAL), .ACT_END(V_ACT_END),
    .SYNC_BEGIN(V_SYNC_BEGIN), .SYNC_END(V_SYNC_END),
    .SE_BEGIN(V_SE_BEGIN), .SE_END(V_SE_END), .SYNC_POL(V_SYNC_POL)
  ) u_v (
    .clock(clock), .nReset(nReset), .step(ce & h_at_end), .clear(resync),
    .count(vCount), .atEnd(v_at_end), .sync(vSync),
    .active(v_act_next), .seActive(v_se_next)
  );

  // Combined windows and strobes registered from next-state so they cannot glitch
  always_ff @(negedge clock or negedge nReset) begin
    if (!nReset) begin
      activeVid  <= VID_AT_ORIGIN;
      activeSE   <= SE_AT_ORIGIN;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      activeVid  <= h_act_next & v_act_next;
      activeSE   <= h_se_next & v_se_next;
      lineStart  <= resync | (ce & h_at_end);
      frameStart <= resync | (ce & h_at_end & v_at_end);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default and small-frame instances)
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam vga_axis_t HA = VGA640_H;
  localparam vga_axis_t VA = VGA640_V;
  localparam vga_axis_t HB = '{total: 20, act_end: 16, sync_begin: 17, sync_end: 19, se_begin: 4, se_end: 12};
  localparam vga_axis_t VB = '{total: 12, act_end: 9, sync_begin: 10, sync_end: 11, se_begin: 2, se_end: 7};

  logic clock = 1'b1;
  always #5 clock = ~clock;

  logic nrst_a, ce_a, rs_a, nrst_b, ce_b, rs_b;
  logic [9:0] hc_a, vc_a;
  logic [5:0] hc_b, vc_b;
  logic hs_a, vs_a, av_a, se_a, ls_a, fs_a;
  logic hs_b, vs_b, av_b, se_b, ls_b, fs_b;

  vga_timing_gen dut_a (
    .clock(clock), .nReset(nrst_a), .ce(ce_a), .resync(rs_a),
    .hCount(hc_a), .vCount(vc_a), .hSync(hs_a), .vSync(vs_a),
    .activeVid(av_a), .activeSE(se_a), .lineStart(ls_a), .frameStart(fs_a)
  );

  vga_timing_gen #(
    .CW(6),
    .H_TOTAL(HB.total), .H_ACT_END(HB.act_end), .H_SYNC_BEGIN(HB.sync_begin),
    .H_SYNC_END(HB.sync_end), .H_SE_BEGIN(HB.se_begin), .H_SE_END(HB.se_end),
    .V_TOTAL(VB.total), .V_ACT_END(VB.act_end), .V_SYNC_BEGIN(VB.sync_begin),
    .V_SYNC_END(VB.sync_end), .V_SE_BEGIN(VB.se_begin), .V_SE_END(VB.se_end),
    .H_SYNC_POL(SYNC_ACTIVE_HIGH), .V_SYNC_POL(SYNC_ACTIVE_LOW)
  ) dut_b (
    .clock(clock), .nReset(nrst_b), .ce(ce_b), .resync(rs_b),
    .hCount(hc_b), .vCount(vc_b), .hSync(hs_b), .vSync(vs_b),
    .activeVid(av_b), .activeSE(se_b), .lineStart(ls_b), .frameStart(fs_b)
  );

  int total_checks = 0;
  int passed = 0;

  // Reference state: linear position within the frame plus strobe flags
  int   pos_a, pos_b;
  logic mls_a, mfs_a, mls_b, mfs_b;

  typedef struct {
    logic ce;
    logic rs;
    int   h;
    int   v;
    logic ls;
    logic fs;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_step(input vga_axis_t h, input vga_axis_t v, input logic nrst,
                            input logic ce, input logic rs,
                            inout int pos, inout logic ls, inout logic fs);
    if (!nrst) begin
      pos = 0; ls = 1'b0; fs = 1'b0;
    end else if (rs) begin
      pos = 0; ls = 1'b1; fs = 1'b1;
    end else if (ce) begin
      pos = (pos + 1) % int'(h.total * v.total);
      ls = (pos % int'(h.total)) == 0;
      fs = (pos == 0);
    end else begin
      ls = 1'b0; fs = 1'b0;
    end
  endtask

  task automatic check_model(input string tag, input vga_axis_t hp, input vga_axis_t vp,
                             input logic hpol, input logic vpol, input int pos,
                             input logic mls, input logic mfs,
                             input int hc, input int vc, input logic hs, input logic vs,
                             input logic av, input logic se, input logic ls, input logic fs);
    int h, v;
    logic e_hs, e_vs, e_av, e_se;
    h = pos % int'(hp.total);
    v = pos / int'(hp.total);
    e_hs = (h >= int'(hp.sync_begin) && h < int'(hp.sync_end)) ? hpol : ~hpol;
    e_vs = (v >= int'(vp.sync_begin) && v < int'(vp.sync_end)) ? vpol : ~vpol;
    e_av = (h < int'(hp.act_end)) && (v < int'(vp.act_end));
    e_se = (h >= int'(hp.se_begin) && h < int'(hp.se_end)) &&
           (v >= int'(vp.se_begin) && v < int'(vp.se_end));
    chk({tag, " hCount"}, hc, h);
    chk({tag, " vCount"}, vc, v);
    chk({tag, " hSync"}, int'(hs), int'(e_hs));
    chk({tag, " vSync"}, int'(vs), int'(e_vs));
    chk({tag, " activeVid"}, int'(av), int'(e_av));
    chk({tag, " activeSE"}, int'(se), int'(e_se));
    chk({tag, " lineStart"}, int'(ls), int'(mls));
    chk({tag, " frameStart"}, int'(fs), int'(mfs));
  endtask

  task automatic check_a(input string tag);
    check_model(tag, HA, VA, 1'b0, 1'b0, pos_a, mls_a, mfs_a, int'(hc_a), int'(vc_a),
                hs_a, vs_a, av_a, se_a, ls_a, fs_a);
  endtask

  task automatic check_b(input string tag);
    check_model(tag, HB, VB, 1'b1, 1'b0, pos_b, mls_b, mfs_b, int'(hc_b), int'(vc_b),
                hs_b, vs_b, av_b, se_b, ls_b, fs_b);
  endtask

  // One pixel clock: DUT updates on the falling edge, outputs sampled after the rising edge
  task automatic tick();
    @(negedge clock);
    model_step(HA, VA, nrst_a, ce_a, rs_a, pos_a, mls_a, mfs_a);
    model_step(HB, VB, nrst_b, ce_b, rs_b, pos_b, mls_b, mfs_b);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int hs_low, av_high, n_ls, n_fs, n_se;
    nrst_a = 1'b0; ce_a = 1'b0; rs_a = 1'b0;
    nrst_b = 1'b0; ce_b = 1'b0; rs_b = 1'b0;
    pos_a = 0; mls_a = 1'b0; mfs_a = 1'b0;
    pos_b = 0; mls_b = 1'b0; mfs_b = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 799, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 799, 1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0,   0, 2, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0,   0, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0,   1, 2, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1,   0, 0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0,   1, 0, 1'b0, 1'b0};

    #1;
    repeat (3) tick();
    chk("reset a hCount", int'(hc_a), 0);
    chk("reset a vCount", int'(vc_a), 0);
    chk("reset a hSync", int'(hs_a), 1);
    chk("reset a vSync", int'(vs_a), 1);
    chk("reset a activeVid", int'(av_a), 1);
    chk("reset a activeSE", int'(se_a), 0);
    chk("reset a lineStart", int'(ls_a), 0);
    chk("reset a frameStart", int'(fs_a), 0);
    chk("reset b hSync", int'(hs_b), 0);
    chk("reset b vSync", int'(vs_b), 1);
    nrst_a = 1'b1; nrst_b = 1'b1;

    // Line 0 scan on the 640x480 instance
    hs_low = 0; av_high = 0;
    ce_a = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (!hs_a) hs_low++;
      if (av_a) av_high++;
      tick();
      check_a("scan a");
    end
    chk("scan a hSync low cycles", hs_low, 96);
    chk("scan a activeVid high cycles", av_high, 640);
    repeat (799) tick();
    check_a("to 799 a");

    // ce toggling at the line end, then resync beating ce
    for (int i = 0; i < 7; i++) begin
      ce_a = vecs[i].ce; rs_a = vecs[i].rs;
      tick();
      chk($sformatf("vec%0d hCount", i), int'(hc_a), vecs[i].h);
      chk($sformatf("vec%0d vCount", i), int'(vc_a), vecs[i].v);
      chk($sformatf("vec%0d lineStart", i), int'(ls_a), int'(vecs[i].ls));
      chk($sformatf("vec%0d frameStart", i), int'(fs_a), int'(vecs[i].fs));
    end
    rs_a = 1'b0; ce_a = 1'b0;

    // Randomised ce/resync on the small-frame instance
    for (int i = 0; i < 3000; i++) begin
      ce_b = ($urandom_range(0, 3) != 0);
      rs_b = ($urandom_range(0, 63) == 0);
      tick();
      check_b("rand b");
    end

    // One full small frame from a resync with ce held high
    ce_b = 1'b0; rs_b = 1'b1;
    tick();
    check_b("resync b");
    rs_b = 1'b0; ce_b = 1'b1;
    n_ls = 0; n_fs = 0; n_se = 0;
    for (int i = 0; i < 240; i++) begin
      tick();
      check_b("frame b");
      if (ls_b) n_ls++;
      if (fs_b) n_fs++;
      if (se_b) n_se++;
    end
    chk("frame b lineStart count", n_ls, 12);
    chk("frame b frameStart count", n_fs, 1);
    chk("frame b activeSE cycles", n_se, 40);
    chk("frame b end hCount", int'(hc_b), 0);
    chk("frame b end vCount", int'(vc_b), 0);

    // Mid-line asynchronous reset pulse on both instances
    ce_a = 1'b1; ce_b = 1'b1;
    repeat (699) tick();
    check_a("pre-reset a");
    chk("pre-reset a hSync", int'(hs_a), 0);
    ce_a = 1'b0; ce_b = 1'b0;
    nrst_a = 1'b0; nrst_b = 1'b0;
    #1;
    chk("async reset a hCount", int'(hc_a), 0);
    chk("async reset a vCount", int'(vc_a), 0);
    chk("async reset a hSync", int'(hs_a), 1);
    chk("async reset a vSync", int'(vs_a), 1);
    chk("async reset a activeVid", int'(av_a), 1);
    chk("async reset b hCount", int'(hc_b), 0);
    chk("async reset b hSync", int'(hs_b), 0);
    chk("async reset b vSync", int'(vs_b), 1);
    #1;
    nrst_a = 1'b1; nrst_b = 1'b1;
    pos_a = 0; mls_a = 1'b0; mfs_a = 1'b0;
    pos_b = 0; mls_b = 1'b0; mfs_b = 1'b0;
    ce_a = 1'b1; ce_b = 1'b1;
    tick();
    check_a("post-reset a");
    check_b("post-reset b");
    chk("post-reset a hCount", int'(hc_a), 1);

    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end

endmodule
